csr_unit_m: RTL

//  Parametrised machine-mode CSR unit, successor of the single-cycle CSR controller.

---
 rtl/csr_pkg.sv | 28 ++
 rtl/csr_counter.sv | 40 ++++
 rtl/csr_unit_m.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, funct3 op
// codes and mstatus bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_t;

endpackage

// File: rtl/csr_counter.sv
// Free-running counter of width CNT_W with 32-bit half writes.
// A write to either half replaces that half and suppresses the increment
// for this cycle; the count wraps to zero after all-ones.
module csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] value_q, value_d;
  logic [63:0]      merged;

  // Next count: half-write replaces bits, otherwise optional increment.
  always_comb begin
    merged  = 64'(value_q);
    value_d = value_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) merged[31:0]  = wdata_i;
      if (wr_hi_i) merged[63:32] = wdata_i;
      value_d = merged[CNT_W-1:0];
    end else if (inc_i) begin
      value_d = value_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/csr_unit_m.sv
// Machine-mode CSR unit: mstatus (MIE/MPIE), mie, mtvec, mscratch, mepc,
// mcause, with trap/mret stacking and illegal-access detection.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined;
// otherwise their addresses decode as unmapped.
module csr_unit_m
  import csr_pkg::*;
#(
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0,
  parameter logic        MTVEC_VEC = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trap_i,
  input  logic        mret_i,
  input  logic        retire_i,
  input  logic [2:0]  opcode_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] imm_data_i,
  input  logic        write_enable_i,
  output logic [31:0] read_data_o,
  output logic        illegal_o,
  output logic [31:0] mie_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtvec_o,
  output logic        irq_en_o
);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic [31:0] operand, old_val, wdata;
  logic        mapped, op_valid, is_rw, wr_intent, read_only, csr_wr;

`ifdef CSR_COUNTERS_EN
  logic [CNT_W-1:0] mcycle_val, minstret_val;
  logic [63:0]      mcycle_ext, minstret_ext;
  assign mcycle_ext   = 64'(mcycle_val);
  assign minstret_ext = 64'(minstret_val);
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  assign operand = opcode_i[2] ? imm_data_i : rs1_data_i;

  // Address decode and read mux (pre-edge value of the addressed CSR).
  always_comb begin
    mapped  = 1'b1;
    old_val = 32'h0;
    case (addr_i)
      CSR_MSTATUS: begin
        old_val[MSTATUS_MIE]  = mstatus_mie_q;
        old_val[MSTATUS_MPIE] = mstatus_mpie_q;
      end
      CSR_MIE:       old_val = mie_q;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    old_val = mcycle_ext[31:0];
      CSR_MCYCLEH:   old_val = mcycle_ext[63:32];
      CSR_MINSTRET:  old_val = minstret_ext[31:0];
      CSR_MINSTRETH: old_val = minstret_ext[63:32];
`endif
      default:       mapped  = 1'b0;
    endcase
  end

  // Operation decode and the value an accepted write would store.
  always_comb begin
    op_valid = 1'b1;
    is_rw    = 1'b0;
    wdata    = old_val;
    case (opcode_i)
      CSR_OP_RW, CSR_OP_RWI: begin
        is_rw = 1'b1;
        wdata = operand;
      end
      CSR_OP_RS, CSR_OP_RSI: wdata = old_val | operand;
      CSR_OP_RC, CSR_OP_RCI: wdata = old_val & ~operand;
      default:               op_valid = 1'b0;
    endcase
  end

  // Set/clear with a zero operand is a pure read, so it may target read-only space.
  assign wr_intent   = op_valid && (is_rw || (operand != 32'h0));
  assign read_only   = (addr_i[11:10] == 2'b11);
  assign illegal_o   = write_enable_i && (!mapped || (read_only && wr_intent));
  assign csr_wr      = write_enable_i && !illegal_o && wr_intent;
  assign read_data_o = illegal_o ? 32'h0 : old_val;

  // Next-state for each CSR: trap > CSR write > mret.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;

    if (trap_i) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (csr_wr && addr_i == CSR_MSTATUS) begin
      mstatus_mie_d  = wdata[MSTATUS_MIE];
      mstatus_mpie_d = wdata[MSTATUS_MPIE];
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    if (trap_i)                            mepc_d = {pc_i[31:2], 2'b00};
    else if (csr_wr && addr_i == CSR_MEPC) mepc_d = {wdata[31:2], 2'b00};

    if (trap_i)                              mcause_d = mcause_i;
    else if (csr_wr && addr_i == CSR_MCAUSE) mcause_d = wdata;

    if (csr_wr && addr_i == CSR_MIE)      mie_d      = wdata;
    if (csr_wr && addr_i == CSR_MSCRATCH) mscratch_d = wdata;
    if (csr_wr && addr_i == CSR_MTVEC)
      mtvec_d = MTVEC_VEC ? wdata : {wdata[31:2], 2'b00};
  end

  // CSR registers with synchronous reset; a reset drops any pending write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (csr_wr && addr_i == CSR_MCYCLE),
    .wr_hi_i (csr_wr && addr_i == CSR_MCYCLEH),
    .wdata_i (wdata),
    .value_o (mcycle_val)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (retire_i),
    .wr_lo_i (csr_wr && addr_i == CSR_MINSTRET),
    .wr_hi_i (csr_wr && addr_i == CSR_MINSTRETH),
    .wdata_i (wdata),
    .value_o (minstret_val)
  );
`endif

  assign mie_o    = mie_q;
  assign mepc_o   = mepc_q;
  assign mtvec_o  = mtvec_q;
  assign irq_en_o = mstatus_mie_q;

endmodule
